bias_col_sched: RTL

Column scheduler for the shared bias stage. It accepts one vector of COLS kernel accumulators per transaction and issues the columns one per cycle to a single bias-add stage, adding each column's bias from an internal bias register file. It collects the registered results and presents the full biased vector downstream with a valid/ready handshake. It sits between the kernel accumulation array and the activation/requantization stage, replacing COLS parallel bias adders with one time-shared stage.

---
 rtl/bias_col_sched.sv | 107 ++++++++++
 1 files changed

// File: rtl/bias_col_sched.sv
// Column scheduler that time-shares one external bias-add stage across COLS
// accumulator columns and returns the assembled biased vector downstream.
module bias_col_sched #(
    parameter int COLS  = 5,
    parameter int B_BW  = 8,
    parameter int AC_BW = 24,
    parameter int AB_BW = 25,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CW-1:0]         cfg_addr,
    input  logic [B_BW-1:0]       cfg_bias,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [COLS*AC_BW-1:0] s_acc,
    output logic                  bias_en,
    output logic [AC_BW-1:0]      bias_acc_kernel,
    output logic [B_BW-1:0]       bias_bias,
    input  logic [AB_BW-1:0]      bias_acc_bias,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [COLS*AB_BW-1:0] m_acc_bias,
    output logic                  busy
);

    // state | meaning
    // IDLE  | waiting for an input vector, s_ready high
    // ISSUE | one column per cycle sent to the bias stage
    // DRAIN | capture the last column's registered result
    // OUT   | biased vector presented, held until m_ready
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    state_t           state;
    logic [CW-1:0]    col;
    logic [CW-1:0]    dly_col;
    logic             dly_valid;
    logic [AC_BW-1:0] in_buf  [COLS];
    logic [AB_BW-1:0] out_buf [COLS];
    logic [B_BW-1:0]  bias_rf [COLS];

    // Writes land at the clock edge, so an issue in the same cycle still sees the old bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COLS; i++) bias_rf[i] <= '0;
        end else if (cfg_we && (cfg_addr <= LAST_COL)) begin
            bias_rf[cfg_addr] <= cfg_bias;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            dly_valid <= 1'b0;
            dly_col   <= '0;
            for (int i = 0; i < COLS; i++) begin
                in_buf[i]  <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            // The bias stage answers one cycle after the issue, so track the issue one cycle late.
            dly_valid <= (state == ISSUE);
            dly_col   <= col;
            if (dly_valid) out_buf[dly_col] <= bias_acc_bias;

            case (state)
                IDLE: begin
                    if (s_valid) begin
                        for (int i = 0; i < COLS; i++) in_buf[i] <= s_acc[i*AC_BW +: AC_BW];
                        col   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= DRAIN;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: state <= OUT;
                OUT: begin
                    if (m_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ready         = (state == IDLE);
    assign busy            = (state != IDLE);
    assign m_valid         = (state == OUT);
    assign bias_en         = (state == ISSUE);
    assign bias_acc_kernel = bias_en ? in_buf[col]  : '0;
    assign bias_bias       = bias_en ? bias_rf[col] : '0;

    always_comb begin
        m_acc_bias = '0;
        for (int i = 0; i < COLS; i++) m_acc_bias[i*AB_BW +: AB_BW] = out_buf[i];
    end

endmodule
